seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed 7-segment display scanner.
//
// A prescaler divides clk into digit slots of DIV cycles; a digit index walks
// 0..NUM_DIGITS-1, one slot each, so a frame is NUM_DIGITS*DIV cycles. The
// first BLANK_CYC cycles of every slot keep all anodes dark to avoid ghosting.
// New display values are taken into a one-entry pending buffer and copied to
// the active buffer only at a frame boundary, so a frame never mixes old and
// new digits.
//
// Load handshake: a transfer happens on every rising clk edge where
// load_valid && load_ready. load_ready is high exactly when the pending
// buffer is empty. It drops the cycle after a transfer and rises again the
// cycle after the frame end that moves pending into active. While
// load_ready is low, load_valid is ignored.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   load_valid  new value offered on load_data/load_dp
//   load_ready  pending buffer empty (load accepted when valid)
//   load_data   4*NUM_DIGITS hex nibbles, nibble 0 = rightmost digit
//   load_dp     decimal point per digit
//   lz_en       leading-zero suppression, sampled live
//   blank       force all anodes inactive, sampled live
//   anode       registered digit enables, bit i = digit i
//   seg         registered segments {g,f,e,d,c,b,a}
//   dp          registered decimal point
//   frame_done  one-cycle pulse after the last slot of a frame
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV            = 100000,
  parameter int BLANK_CYC      = 2,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    lz_en,
  input  logic                    blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  // XOR masks that convert internal active-high values to pin polarity;
  // they are also the "inactive" pin levels.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    frame_done_q, frame_done_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_end, frame_end, load_fire;
  logic [NUM_DIGITS-1:0]   hi_nz;   // hi_nz[i]: some nibble at position >= i is nonzero
  logic                    nz_acc;
  logic [3:0]              cur_nib;
  logic                    cur_dp, lz_hide, an_on;
  logic [NUM_DIGITS-1:0]   onehot;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    load_fire = load_valid && !pend_q;

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    frame_done_d = frame_end;

    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    // Only one of these can fire in a cycle: load_fire needs pend_q=0, the
    // copy needs pend_q=1. A load landing on the frame-end cycle therefore
    // waits a full frame for the next boundary.
    if (frame_end && pend_q) begin
      act_data_d = pend_data_q;
      act_dp_d   = pend_dp_q;
      pend_d     = 1'b0;
    end
    if (load_fire) begin
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
      pend_d      = 1'b1;
    end

    hi_nz  = '0;
    nz_acc = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_acc   = nz_acc | (|act_data_q[i*4 +: 4]);
      hi_nz[i] = nz_acc;
    end

    cur_nib = act_data_q[idx_q*4 +: 4];
    cur_dp  = act_dp_q[idx_q];
    // Suppressed digits keep their anode only when their dp must be shown.
    lz_hide = lz_en && (idx_q != '0) && !hi_nz[idx_q];
    an_on   = !blank && (cnt_q >= BLANK_LIM) && !(lz_hide && !cur_dp);
    onehot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;

    anode_d = (an_on ? onehot : '0) ^ AN_OFF;
    seg_d   = (lz_hide ? 7'h00 : hex_to_seg(cur_nib)) ^ SEG_OFF;
    dp_d    = cur_dp ^ DP_OFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      anode_q      <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign load_ready = !pend_q;
  assign anode      = anode_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
